// File: rtl/acs_stage.sv
//----------------------------------------------------------------------------
// Module      : acs_stage
// Description : Add-compare-select stage for a K=4, 8-state Viterbi decoder
//               (generators g0 = 1101, g1 = 1111). Each accepted soft symbol
//               pair advances the trellis by one step. The stage produces
//               per-state survivor decisions and the index of the best new
//               path metric. Output is a one-deep valid/ready register.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               start               - first symbol of a frame
//               y0, y1              - unsigned soft symbols for g0 / g1 bits
//               out_valid/out_ready - output handshake
//               decision[7:0]       - bit j = 1 -> odd predecessor survived
//               best_state[2:0]     - lowest index of minimum new metric
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module acs_stage #(
  parameter int SOFT_W  = 3,
  parameter int PM_W    = 8,
  parameter int PM_INIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  input  logic [SOFT_W-1:0] y0,
  input  logic [SOFT_W-1:0] y1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        decision,
  output logic [2:0]        best_state
);

  localparam int              c_NS      = 8;
  localparam int              c_BM_W    = SOFT_W + 1;
  localparam logic [SOFT_W-1:0] c_SMAX  = '1;
  localparam logic [PM_W-1:0] c_PM_INIT = PM_W'(PM_INIT);

  // Soft distance of symbol y from an expected code bit c.
  function automatic logic [c_BM_W-1:0] f_dist(input logic [SOFT_W-1:0] y,
                                               input logic              c);
    return c ? {1'b0, c_SMAX - y} : {1'b0, y};
  endfunction

  // Branch metric for leaving predecessor p on input bit b.
  function automatic logic [c_BM_W-1:0] f_bm(input logic [2:0]        p,
                                             input logic              b,
                                             input logic [SOFT_W-1:0] a0,
                                             input logic [SOFT_W-1:0] a1);
    logic [3:0] r;
    logic       c0;
    logic       c1;
    r  = {b, p};
    c0 = ^(r & 4'b1101);
    c1 = ^r;
    return f_dist(a0, c0) + f_dist(a1, c1);
  endfunction

  logic [PM_W-1:0] r_pm [c_NS];
  logic [7:0]      r_decision;
  logic [2:0]      r_best;
  logic            r_out_valid;

  logic            w_accept;
  logic [PM_W-1:0] w_old  [c_NS];
  logic [PM_W:0]   w_cand0 [c_NS];
  logic [PM_W:0]   w_cand1 [c_NS];
  logic [PM_W-1:0] w_sel  [c_NS];
  logic [PM_W-1:0] w_norm [c_NS];
  logic [7:0]      w_dec;
  logic [7:0]      w_msb;
  logic            w_all_msb;
  logic [2:0]      w_best;
  logic [PM_W-1:0] w_min;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = r_out_valid;
  assign decision   = r_decision;
  assign best_state = r_best;

  for (genvar j = 0; j < c_NS; j++) begin : g_acs
    localparam logic [2:0] c_P0 = 3'(2 * (j % 4));
    localparam logic [2:0] c_P1 = 3'(2 * (j % 4) + 1);
    localparam logic       c_B  = (j >= 4);

    // A frame start replaces the stored metrics with the known-state prior.
    assign w_old[j]   = start ? ((j == 0) ? '0 : c_PM_INIT) : r_pm[j];

    assign w_cand0[j] = {1'b0, w_old[c_P0]} + (PM_W+1)'(f_bm(c_P0, c_B, y0, y1));
    assign w_cand1[j] = {1'b0, w_old[c_P1]} + (PM_W+1)'(f_bm(c_P1, c_B, y0, y1));

    // Ties keep the even predecessor.
    assign w_dec[j]   = (w_cand1[j] < w_cand0[j]);
    assign w_sel[j]   = w_dec[j] ? w_cand1[j][PM_W-1:0] : w_cand0[j][PM_W-1:0];
    assign w_msb[j]   = w_sel[j][PM_W-1];

    // Metrics only matter relative to each other, so dropping a shared MSB
    // keeps them bounded without changing any decision.
    assign w_norm[j]  = w_all_msb ? {1'b0, w_sel[j][PM_W-2:0]} : w_sel[j];
  end

  assign w_all_msb = &w_msb;

  always_comb begin
    w_best = '0;
    w_min  = w_norm[0];
    for (int j = 1; j < c_NS; j++) begin
      if (w_norm[j] < w_min) begin
        w_min  = w_norm[j];
        w_best = 3'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NS; i++) begin
        r_pm[i] <= (i == 0) ? '0 : c_PM_INIT;
      end
      r_decision  <= '0;
      r_best      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < c_NS; i++) begin
        r_pm[i] <= w_norm[i];
      end
      r_decision  <= w_dec;
      r_best      <= w_best;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acs_stage.sv
//----------------------------------------------------------------------------
// Module      : tb_acs_stage
// Description : Self-checking bench for acs_stage against a trellis-level
//               reference model (encoder parity, soft distances, min search).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_acs_stage;

  localparam int SOFT_W  = 3;
  localparam int PM_W    = 8;
  localparam int PM_INIT = 64;
  localparam int SMAX    = (1 << SOFT_W) - 1;
  localparam int PM_MOD  = 1 << PM_W;
  localparam int PM_HALF = 1 << (PM_W - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              start = 1'b0;
  logic [SOFT_W-1:0] y0 = '0;
  logic [SOFT_W-1:0] y1 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        decision;
  logic [2:0]        best_state;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_norm = 0;
  int n_tie  = 0;

  // Reference model state
  int m_pm [8];
  bit m_ov;
  int m_dec;
  int m_best;

  always #5 clk = ~clk;

  acs_stage #(
    .SOFT_W (SOFT_W),
    .PM_W   (PM_W),
    .PM_INIT(PM_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .y0        (y0),
    .y1        (y1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .decision  (decision),
    .best_state(best_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pm[i] = (i == 0) ? 0 : PM_INIT;
    m_dec  = 0;
    m_best = 0;
    m_ov   = 1'b0;
  endtask

  // One trellis step computed from the encoder definition.
  task automatic model_step(input bit s, input int a, input int b);
    int old [8];
    int nv  [8];
    int cand [2];
    int dec;
    bit all_hi;
    for (int i = 0; i < 8; i++) old[i] = s ? ((i == 0) ? 0 : PM_INIT) : m_pm[i];
    dec = 0;
    for (int j = 0; j < 8; j++) begin
      for (int d = 0; d < 2; d++) begin
        int p, rr, c0, c1;
        p  = 2 * (j % 4) + d;
        rr = ((j >> 2) << 3) | p;
        c0 = $countones(rr & 13) % 2;
        c1 = $countones(rr & 15) % 2;
        cand[d] = old[p] + (c0 ? SMAX - a : a) + (c1 ? SMAX - b : b);
      end
      if (cand[1] == cand[0]) n_tie++;
      if (cand[1] < cand[0]) begin
        dec |= (1 << j);
        nv[j] = cand[1] % PM_MOD;
      end else begin
        nv[j] = cand[0] % PM_MOD;
      end
    end
    all_hi = 1'b1;
    for (int j = 0; j < 8; j++) if (nv[j] < PM_HALF) all_hi = 1'b0;
    if (all_hi) begin
      n_norm++;
      for (int j = 0; j < 8; j++) nv[j] -= PM_HALF;
    end
    m_best = 0;
    for (int j = 1; j < 8; j++) if (nv[j] < nv[m_best]) m_best = j;
    for (int j = 0; j < 8; j++) m_pm[j] = nv[j];
    m_dec = dec;
    m_ov  = 1'b1;
  endtask

  // Drive one cycle of inputs, check ready, clock, then check all state.
  task automatic step(input bit v, input bit s, input int a, input int b,
                      input bit ordy, input bit r);
    bit exp_ready;
    @(negedge clk);
    in_valid  = v;
    start     = s;
    y0        = SOFT_W'(a);
    y1        = SOFT_W'(b);
    out_ready = ordy;
    rst       = r;
    #1;
    exp_ready = !m_ov || ordy;
    chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (r)                    model_reset();
    else if (v && exp_ready)  model_step(s, a, b);
    else if (m_ov && ordy)    m_ov = 1'b0;
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("decision", decision, m_dec);
    chk("best_state", best_state, m_best);
    for (int i = 0; i < 8; i++) chk($sformatf("pm%0d", i), dut.r_pm[i], m_pm[i]);
  endtask

  task automatic rnd_step(input bit v, input bit ordy);
    step(v, 1'b0, int'($urandom_range(SMAX)), int'($urandom_range(SMAX)), ordy, 1'b0);
  endtask

  initial begin
    model_reset();

    // Reset state, then first idle cycle must be ready.
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);

    // Clean all-zero frame: state 0 stays best with zero metric.
    step(1, 1, 0, 0, 1, 0);
    chk("first_pm0", dut.r_pm[0], 0);
    chk("first_dec0", decision[0], 1'b0);
    for (int k = 0; k < 9; k++) step(1, 0, 0, 0, 1, 0);

    // Back-pressure: five stalled cycles, then consume-and-accept.
    for (int k = 0; k < 5; k++) rnd_step(1, 0);
    rnd_step(1, 1);
    rnd_step(1, 1);

    // Mid-scale symbols grow every metric and force normalization.
    for (int k = 0; k < 40; k++) step(1, 0, 3, 4, 1, 0);

    // Randomized traffic with occasional frame starts.
    for (int k = 0; k < 500; k++) begin
      step(($urandom % 4) != 0, ($urandom % 64) == 0,
           int'($urandom_range(SMAX)), int'($urandom_range(SMAX)),
           ($urandom % 4) != 0, 1'b0);
    end

    // Reset while a step is pending and another is offered.
    rnd_step(1, 1);
    rnd_step(1, 0);
    step(1, 0, 5, 2, 0, 1);
    chk("rst_drop_ov", out_valid, 1'b0);
    step(0, 0, 0, 0, 0, 0);

    // History, then a mid-stream restart must behave like a fresh frame.
    for (int k = 0; k < 30; k++) rnd_step(1, 1);
    step(1, 1, 0, 0, 1, 0);
    chk("restart_pm0", dut.r_pm[0], 0);
    for (int k = 0; k < 10; k++) rnd_step(1, 1);

    chk("norm_hit", n_norm > 0, 1);
    chk("tie_hit", n_tie > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
